ce_reset_gen: RTL
=================

# ce_reset_gen

Clock-enable and core-reset sequencer sitting directly downstream of the system PLL. Runs on the 24 MHz PLL output, synchronises the PLL `locked` flag, holds the arcade core in reset until the clock is stable and then for a programmable number of cycles. Generates single-cycle clock-enable strobes for the pixel pipeline (integer divide), the main CPU and the sound CPU/PSG (fractional phase-accumulator divide), so the whole core runs on one clock.

## Interface
- `PIX_DIV`, 4, integer divider for `ce_pix` (2..16); 24 MHz / 4 = 6 MHz.
- `CPU_NUM`, 16, main-CPU accumulator increment.
- `CPU_DEN`, 125, main-CPU accumulator modulus; 24 MHz × 16/125 = 3.072 MHz.
- `SND_NUM`, 179, sound accumulator increment.
- `SND_DEN`, 2400, sound accumulator modulus; 24 MHz × 179/2400 = 1.79 MHz.
- `ACC_W`, 12, accumulator width; requires 0 < NUM < DEN and DEN + NUM < 2^ACC_W.
- `RST_CYCLES`, 256, cycles of core reset held after lock (1..65535).

- `clk_sys` in 1 system clock, 24 MHz from the PLL.
- `reset` in 1 synchronous, active-high; one clock, reset is synchronous and active-high.
- `pll_locked` in 1 PLL locked flag, asynchronous to `clk_sys`.
- `pause` in 1 level; suppresses `ce_cpu` only.
- `core_reset` out 1 active-high reset to the rest of the core.
- `ce_pix` out 1 pixel clock enable.
- `ce_cpu` out 1 main-CPU clock enable.
- `ce_snd` out 1 sound CPU / PSG clock enable.

## Operation
- `pll_locked` passes through a 2-flop synchroniser (`lock_m`, `lock_s`); FSM uses `lock_s` only.
- FSM states: WAIT_LOCK, HOLD, RUN.
  - WAIT_LOCK: `core_reset`=1, all enables 0, pix counter and both accumulators held at 0, hold counter 0. `lock_s`=1 -> HOLD.
  - HOLD: `core_reset`=1, enable generators running (CPUs receive clocks while in reset). Hold counter increments each cycle; at count RST_CYCLES-1 -> RUN. `lock_s`=0 -> WAIT_LOCK (takes priority).
  - RUN: `core_reset`=0, enables running. `lock_s`=0 -> WAIT_LOCK.
- Pixel divider: counter 0..PIX_DIV-1 wrapping; `ce_pix` registered high for the cycle after the counter reaches PIX_DIV-1.
- Fractional divider (CPU and SND identical): `sum = acc + NUM`; if `sum >= DEN` then `acc <= sum - DEN`, enable registered 1; else `acc <= sum`, enable 0. Long-run rate exactly NUM/DEN; no two consecutive strobes since NUM < DEN/2.
- `pause`=1 forces `ce_cpu` output to 0; CPU accumulator keeps advancing (phase preserved). `ce_pix`, `ce_snd` unaffected.
- `reset`=1 at any edge: state WAIT_LOCK, synchroniser flops 0, all counters/accumulators 0, `core_reset`=1, enables 0. Overrides all other inputs.

## Timing
- Reset values: `core_reset`=1, `ce_pix`=`ce_cpu`=`ce_snd`=0.
- All outputs registered; no combinational path from any input to any output.
- `pll_locked` rises, first sampled high at edge N: `lock_s`=1 after edge N+1, state HOLD after edge N+2.
- First edge in HOLD is enabled edge 1. `core_reset` falls after edge N+2+RST_CYCLES.
- `ce_pix` first high after enabled edge PIX_DIV, then every PIX_DIV cycles.
- `ce_cpu` first high after enabled edge 8 (16×8=128 ≥ 125), residue 3; exactly 16 strobes per 125 cycles.
- `ce_snd` first high after enabled edge 14 (179×14=2506 ≥ 2400); exactly 179 strobes per 2400 cycles.
- `pll_locked` drop sampled at edge M: WAIT_LOCK after edge M+2; `core_reset`=1 and all enables 0 from that edge; an in-flight strobe is cancelled.
- Re-lock restarts full HOLD sequence; accumulator phase restarts from 0.

## Test plan
- Power-up: `reset`=1 4 cycles, `pll_locked`=0 -> `core_reset`=1, all enables 0 for 1000 cycles.
- Lock at edge N with RST_CYCLES=256 -> `core_reset` falls after edge N+258; `ce_pix` first after edge N+6, then period 4.
- Rate check: run 12 000 cycles after lock -> `ce_cpu` count 1536, `ce_snd` count 895, `ce_pix` count 3000; never two consecutive CPU/SND strobes.
- `pause`=1 for 500 cycles in RUN -> `ce_cpu`=0 throughout, `ce_snd`/`ce_pix` unchanged; on release `ce_cpu` positions match an unpaused reference run.
- Lock loss in RUN then re-lock 50 cycles later -> `core_reset`=1 two edges after drop, enables 0, full 256-cycle HOLD repeated, first `ce_cpu` again after 8th enabled edge.
- `reset` pulsed mid-HOLD (hold counter 100) with `pll_locked`=1 -> WAIT_LOCK next edge, counters 0; HOLD re-entered 2 edges after `reset` released, full 256 cycles.

Source files
------------

// File: rtl/ce_reset_gen.sv
// Clock-enable and core-reset sequencer downstream of the system PLL.
// Synchronises PLL lock, sequences core reset, and divides clk_sys into CE strobes.
module ce_reset_gen #(
   parameter int PIX_DIV    = 4,
   parameter int CPU_NUM    = 16,
   parameter int CPU_DEN    = 125,
   parameter int SND_NUM    = 179,
   parameter int SND_DEN    = 2400,
   parameter int ACC_W      = 12,
   parameter int RST_CYCLES = 256
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic pll_locked,
   input  logic pause,
   output logic core_reset,
   output logic ce_pix,
   output logic ce_cpu,
   output logic ce_snd
);

   // state     | meaning
   // WAIT_LOCK | PLL not locked: core in reset, enables off, all counters cleared
   // HOLD      | PLL locked: enables running, core held in reset for RST_CYCLES
   // RUN       | core released, enables running
   typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

   localparam int PIX_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

   localparam logic [ACC_W-1:0] CPU_NUM_W = ACC_W'(CPU_NUM);
   localparam logic [ACC_W-1:0] CPU_DEN_W = ACC_W'(CPU_DEN);
   localparam logic [ACC_W-1:0] SND_NUM_W = ACC_W'(SND_NUM);
   localparam logic [ACC_W-1:0] SND_DEN_W = ACC_W'(SND_DEN);
   localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);
   localparam logic [15:0]      HOLD_LAST = 16'(RST_CYCLES - 1);

   state_t             state;
   logic               lock_m;
   logic               lock_s;
   logic [15:0]        hold_cnt;
   logic [PIX_W-1:0]   pix_cnt;
   logic [ACC_W-1:0]   cpu_acc;
   logic [ACC_W-1:0]   snd_acc;

   logic [ACC_W-1:0]   cpu_sum;
   logic [ACC_W-1:0]   snd_sum;
   logic               cpu_hit;
   logic               snd_hit;
   logic               gen_run;

   // DEN + NUM fits in ACC_W, so the sums never wrap.
   always_comb begin
      cpu_sum = cpu_acc + CPU_NUM_W;
      snd_sum = snd_acc + SND_NUM_W;
      cpu_hit = (cpu_sum >= CPU_DEN_W);
      snd_hit = (snd_sum >= SND_DEN_W);
      gen_run = (state != WAIT_LOCK) && lock_s;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= WAIT_LOCK;
         lock_m     <= 1'b0;
         lock_s     <= 1'b0;
         hold_cnt   <= '0;
         pix_cnt    <= '0;
         cpu_acc    <= '0;
         snd_acc    <= '0;
         core_reset <= 1'b1;
         ce_pix     <= 1'b0;
         ce_cpu     <= 1'b0;
         ce_snd     <= 1'b0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;

         if (!gen_run) begin
            // Covers both idling in WAIT_LOCK and a lock drop, which cancels any in-flight strobe.
            state      <= (state == WAIT_LOCK && lock_s) ? HOLD : WAIT_LOCK;
            hold_cnt   <= '0;
            pix_cnt    <= '0;
            cpu_acc    <= '0;
            snd_acc    <= '0;
            core_reset <= 1'b1;
            ce_pix     <= 1'b0;
            ce_cpu     <= 1'b0;
            ce_snd     <= 1'b0;
         end else begin
            if (pix_cnt == PIX_LAST) begin
               pix_cnt <= '0;
               ce_pix  <= 1'b1;
            end else begin
               pix_cnt <= pix_cnt + 1'b1;
               ce_pix  <= 1'b0;
            end

            // Pause only masks the strobe; the accumulator keeps its phase.
            if (cpu_hit) begin
               cpu_acc <= cpu_sum - CPU_DEN_W;
               ce_cpu  <= ~pause;
            end else begin
               cpu_acc <= cpu_sum;
               ce_cpu  <= 1'b0;
            end

            if (snd_hit) begin
               snd_acc <= snd_sum - SND_DEN_W;
               ce_snd  <= 1'b1;
            end else begin
               snd_acc <= snd_sum;
               ce_snd  <= 1'b0;
            end

            if (state == HOLD) begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= RUN;
                  hold_cnt   <= '0;
                  core_reset <= 1'b0;
               end else begin
                  hold_cnt   <= hold_cnt + 1'b1;
                  core_reset <= 1'b1;
               end
            end else begin
               core_reset <= 1'b0;
            end
         end
      end
   end

endmodule
